// File: rtl/cpu_pkg.sv
// Shared types and constants for the integer pipeline.
// Contents:
//   XLEN, REG_AW, CMD_W : datapath, register-index and ALU-command widths
//   exe_cmd_e           : ALU operation encoding (CMD_NOP marks an empty slot)
//   id_ex_t             : fields held in the ID/EX pipeline register
//   id_ex_reset()       : cleared ID/EX contents (all zero, command NOP)
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CMD_W  = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_AND = 4'd2,
    CMD_OR  = 4'd3,
    CMD_NOR = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SLL = 4'd6,
    CMD_SLA = 4'd7,
    CMD_SRL = 4'd8,
    CMD_SRA = 4'd9,
    CMD_NOP = 4'd10
  } exe_cmd_e;

  typedef struct packed {
    exe_cmd_e          exe_cmd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  function automatic id_ex_t id_ex_reset();
    id_ex_t v;
    v         = '0;
    v.exe_cmd = CMD_NOP;
    return v;
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: three-source priority forwarding selector for one source operand.
// Ports:
//   i_src                                   : source register index of the held instruction
//   i_held_val                              : value captured from the register file
//   i_exmem_wb_en/i_exmem_rd/i_exmem_result : youngest in-flight producer
//   i_memwb_wb_en/i_memwb_rd/i_memwb_result : older in-flight producer
//   o_val                                   : resolved operand
// The younger EX/MEM result always wins; register 0 is hard-wired and never forwarded.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic [XLEN-1:0]   i_held_val,
  input  logic              i_exmem_wb_en,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]   i_exmem_result,
  input  logic              i_memwb_wb_en,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]   i_memwb_result,
  output logic [XLEN-1:0]   o_val
);

  logic w_src_nz;

  assign w_src_nz = (i_src != {REG_AW{1'b0}});

  // Priority select: EX/MEM, then MEM/WB, then the held register-file value.
  always_comb begin
    o_val = i_held_val;
    if (w_src_nz && i_exmem_wb_en && (i_exmem_rd == i_src)) begin
      o_val = i_exmem_result;
    end else if (w_src_nz && i_memwb_wb_en && (i_memwb_rd == i_src)) begin
      o_val = i_memwb_result;
    end else begin
      o_val = i_held_val;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and
// load-use bubble insertion, feeding the execute ALU.
// Ports:
//   clk, rst_n, flush          : clock, async active-low reset, kill held instruction
//   id_valid/id_ready, id_*    : decoded instruction handshake and fields from ID
//   exmem_*, memwb_*           : writeback buses used as forwarding sources
//   ex_valid/ex_ready          : handshake towards the ALU / EX-MEM register
//   val1, val2, exe_cmd, ex_*  : resolved operands, command and control for EX
// Widths come from cpu_pkg (XLEN, REG_AW, CMD_W).
module ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [CMD_W-1:0]  id_exe_cmd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_wb_en,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_wb_en,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   val1,
  output logic [XLEN-1:0]   val2,
  output logic [CMD_W-1:0]  exe_cmd,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wb_en,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data
);

  id_ex_t          r_ex;
  logic            r_valid;
  id_ex_t          w_id;
  logic            w_advance;
  logic            w_hz;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  assign w_advance = !r_valid || ex_ready;

  // Load-use hazard: a held load whose result the incoming instruction needs
  // cannot be forwarded in time, so the consumer waits one cycle behind a bubble.
  always_comb begin
    w_hz = 1'b0;
    if (r_valid && r_ex.mem_read && (r_ex.rd != {REG_AW{1'b0}})) begin
      w_hz = (id_rs1 == r_ex.rd)
          || (!id_use_imm && (id_rs2 == r_ex.rd))
          || (id_mem_write && (id_rs2 == r_ex.rd));
    end else begin
      w_hz = 1'b0;
    end
  end

  assign id_ready = w_advance && !w_hz && !flush;

  // Pack the incoming ID fields into the pipeline-register layout.
  always_comb begin
    w_id           = id_ex_reset();
    w_id.exe_cmd   = exe_cmd_e'(id_exe_cmd);
    w_id.rs1       = id_rs1;
    w_id.rs2       = id_rs2;
    w_id.rd        = id_rd;
    w_id.rs1_val   = id_rs1_val;
    w_id.rs2_val   = id_rs2_val;
    w_id.imm       = id_imm;
    w_id.use_imm   = id_use_imm;
    w_id.wb_en     = id_wb_en;
    w_id.mem_read  = id_mem_read;
    w_id.mem_write = id_mem_write;
  end

  fwd_mux u_fwd1 (
    .i_src          (r_ex.rs1),
    .i_held_val     (r_ex.rs1_val),
    .i_exmem_wb_en  (exmem_wb_en),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_result (exmem_result),
    .i_memwb_wb_en  (memwb_wb_en),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_result (memwb_result),
    .o_val          (w_fwd1)
  );

  fwd_mux u_fwd2 (
    .i_src          (r_ex.rs2),
    .i_held_val     (r_ex.rs2_val),
    .i_exmem_wb_en  (exmem_wb_en),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_result (exmem_result),
    .i_memwb_wb_en  (memwb_wb_en),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_result (memwb_result),
    .o_val          (w_fwd2)
  );

  // Pipeline register: flush > bubble > load > drain > hold-with-refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ex    <= id_ex_reset();
    end else if (flush) begin
      r_valid          <= 1'b0;
      r_ex.wb_en       <= 1'b0;
      r_ex.mem_read    <= 1'b0;
      r_ex.mem_write   <= 1'b0;
    end else if (w_advance && w_hz) begin
      r_valid          <= 1'b0;
      r_ex.wb_en       <= 1'b0;
      r_ex.mem_read    <= 1'b0;
      r_ex.mem_write   <= 1'b0;
      r_ex.exe_cmd     <= CMD_NOP;
    end else if (w_advance && id_valid) begin
      r_valid <= 1'b1;
      r_ex    <= w_id;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end else begin
      // Stalled: capture forwarded operands so they survive the producer
      // leaving the MEM/WB stage while we wait.
      r_ex.rs1_val <= w_fwd1;
      r_ex.rs2_val <= w_fwd2;
    end
  end

  assign ex_valid      = r_valid;
  assign val1          = w_fwd1;
  assign val2          = r_ex.use_imm ? r_ex.imm : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign exe_cmd       = r_ex.exe_cmd;
  assign ex_rd         = r_ex.rd;
  // Control bits are qualified so an empty slot can never write anything.
  assign ex_wb_en      = r_valid && r_ex.wb_en;
  assign ex_mem_read   = r_valid && r_ex.mem_read;
  assign ex_mem_write  = r_valid && r_ex.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage: reset, forwarding
// priority, load-use bubble, stall refresh, flush, immediate/store operands.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [CMD_W-1:0]  id_exe_cmd;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rs1_val, id_rs2_val, id_imm;
  logic              id_use_imm, id_wb_en, id_mem_read, id_mem_write;
  logic              exmem_wb_en;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_result;
  logic              memwb_wb_en;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_result;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   val1, val2, ex_store_data;
  logic [CMD_W-1:0]  exe_cmd;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wb_en, ex_mem_read, ex_mem_write;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_exe_cmd(id_exe_cmd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .exmem_wb_en(exmem_wb_en), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wb_en(memwb_wb_en), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_clear();
    exmem_wb_en = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_wb_en = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic present(input logic [3:0] cmd, input logic [4:0] rs1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic [31:0] v2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic ui, input logic wb,
                         input logic mr, input logic mw);
    id_valid = 1'b1; id_exe_cmd = cmd;
    id_rs1 = rs1; id_rs1_val = v1; id_rs2 = rs2; id_rs2_val = v2; id_rd = rd;
    id_imm = imm; id_use_imm = ui; id_wb_en = wb; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    present(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    fwd_clear();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid",    32'(ex_valid), 32'd0);
    chk("rst_cmd",      32'(exe_cmd),  32'd10);
    chk("rst_val1",     val1,          32'd0);
    chk("rst_val2",     val2,          32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);

    // Forwarding priority on rs1=5.
    present(4'd0, 5'd5, 32'h0000_AAAA, 5'd6, 32'h0000_BBBB, 5'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    #1;
    chk("a_valid", 32'(ex_valid), 32'd1);
    chk("a_rd",    32'(ex_rd),    32'd9);
    chk("a_wb",    32'(ex_wb_en), 32'd1);
    chk("a_val1",  val1,          32'h0000_AAAA);
    chk("a_val2",  val2,          32'h0000_BBBB);
    exmem_wb_en = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_wb_en = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    chk("fwd_exmem_wins", val1, 32'h11);
    exmem_wb_en = 1'b0;
    #1;
    chk("fwd_memwb", val1, 32'h22);
    fwd_clear();
    ex_ready = 1'b1;
    present(4'd3, 5'd0, 32'h5555, 5'd0, 32'h6666, 5'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    exmem_wb_en = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h11;
    memwb_wb_en = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h22;
    #1;
    chk("x0_val1", val1,          32'h5555);
    chk("x0_val2", val2,          32'h6666);
    chk("x0_cmd",  32'(exe_cmd),  32'd3);

    // Load-use: load rd=3 followed by consumer of x3.
    fwd_clear();
    present(4'd0, 5'd1, 32'h10, 5'd2, 32'h0, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    present(4'd2, 5'd3, 32'h0000_DEAD, 5'd4, 32'h4, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_id_ready_lo", 32'(id_ready),    32'd0);
    chk("lu_load_mr",     32'(ex_mem_read), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid),    32'd0);
    chk("lu_bubble_mr",    32'(ex_mem_read), 32'd0);
    chk("lu_bubble_cmd",   32'(exe_cmd),     32'd10);
    chk("lu_id_ready_hi",  32'(id_ready),    32'd1);
    tick();
    id_valid = 1'b0;
    memwb_wb_en = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h44;
    #1;
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_rd",    32'(ex_rd),    32'd5);
    chk("lu_val1",  val1,          32'h44);

    // Hold refresh: rs2=7 forwarded only during the first stalled cycle.
    fwd_clear();
    present(4'd5, 5'd2, 32'h2, 5'd7, 32'h77, 5'd8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    memwb_wb_en = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h99;
    #1;
    chk("hold_c1_val2",     val2,          32'h99);
    chk("hold_c1_id_ready", 32'(id_ready), 32'd0);
    tick();
    memwb_wb_en = 1'b0;
    #1;
    chk("hold_c2_val2",  val2,          32'h99);
    chk("hold_c2_store", ex_store_data, 32'h99);
    tick();
    chk("hold_c3_val2",  val2,          32'h99);
    chk("hold_c3_valid", 32'(ex_valid), 32'd1);

    // Flush during a stall with a new instruction offered.
    fwd_clear();
    flush = 1'b1;
    present(4'd1, 5'd1, 32'h0000_D00D, 5'd2, 32'h0, 5'd12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fl_id_ready", 32'(id_ready), 32'd0);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    #1;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_wb",    32'(ex_wb_en), 32'd0);
    chk("fl_rd",    32'(ex_rd),    32'd8);
    chk("fl_val1",  val1,          32'h2);

    // Immediate operand with forwarded store data.
    ex_ready = 1'b1;
    present(4'd0, 5'd1, 32'h1, 5'd9, 32'h5, 5'd0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    id_valid = 1'b0;
    exmem_wb_en = 1'b1; exmem_rd = 5'd9; exmem_result = 32'h1234;
    #1;
    chk("imm_val2",  val2,              32'hFFFF_FFF0);
    chk("imm_store", ex_store_data,     32'h1234);
    chk("imm_mw",    32'(ex_mem_write), 32'd1);
    chk("imm_val1",  val1,              32'h1);

    // Store data dependency on a load triggers the hazard even with use_imm.
    fwd_clear();
    present(4'd0, 5'd1, 32'h1, 5'd2, 32'h0, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    present(4'd0, 5'd1, 32'h1, 5'd3, 32'h0, 5'd0, 32'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("st_hz_id_ready", 32'(id_ready), 32'd0);
    id_mem_write = 1'b0;
    #1;
    chk("imm_no_hz_id_ready", 32'(id_ready), 32'd1);

    // Asynchronous reset in the middle of a stall.
    id_valid = 1'b0; ex_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid),    32'd0);
    chk("arst_cmd",   32'(exe_cmd),     32'd10);
    chk("arst_val1",  val1,             32'd0);
    chk("arst_val2",  val2,             32'd0);
    chk("arst_mr",    32'(ex_mem_read), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-resolution stage directly upstream of the execute ALU.
- Latches decoded instructions from ID and resolves EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Presents val1, val2 and exe_cmd to the ALU every cycle, with valid/ready flow control on both sides.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.
- CMD_W, 4, width of exe_cmd.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction held in the stage (branch mispredict)
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_exe_cmd  in  CMD_W  ALU operation
- id_rs1, id_rs2, id_rd  in  REG_AW  source/destination indices
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate
- id_use_imm  in  1  val2 takes imm instead of rs2
- id_wb_en, id_mem_read, id_mem_write  in  1  control bits
- exmem_wb_en  in  1  EX/MEM writeback valid
- exmem_rd  in  REG_AW  EX/MEM destination index
- exmem_result  in  XLEN  EX/MEM result
- memwb_wb_en  in  1  MEM/WB writeback valid
- memwb_rd  in  REG_AW  MEM/WB destination index
- memwb_result  in  XLEN  MEM/WB result
- ex_valid  out  1  held instruction is valid
- ex_ready  in  1  downstream (ALU/EX-MEM register) accepts
- val1, val2  out  XLEN  ALU operands
- exe_cmd  out  CMD_W  ALU command
- ex_rd  out  REG_AW  destination index
- ex_wb_en, ex_mem_read, ex_mem_write  out  1  control bits
- ex_store_data  out  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0; all held fields cleared; exe_cmd=CMD_NOP; val1=val2=ex_store_data=0; ex_rd=0; all control outputs 0.
- advance = !ex_valid | ex_ready.
- Load-use hazard, hz = ex_valid & ex_mem_read & ex_rd!=0 & (id_rs1==ex_rd | (!id_use_imm & id_rs2==ex_rd) | (id_mem_write & id_rs2==ex_rd)).
- id_ready = advance & !hz & !flush. Combinational; no dependency on id_valid.
- Register update priority, highest first:
  1. flush: ex_valid<=0. The ID input is dropped; ID is responsible for flushing itself too.
  2. advance & hz: bubble. ex_valid<=0, control bits cleared, exe_cmd<=CMD_NOP.
  3. advance & id_valid: load all id_* fields, ex_valid<=1.
  4. advance & !id_valid: ex_valid<=0.
  5. hold (ex_valid & !ex_ready): fields unchanged, except rs1_val/rs2_val are overwritten with their currently forwarded values. This keeps operands correct if the producer retires from MEM/WB during the stall.
- Forwarding, combinational from held fields (fwd1 shown; fwd2 identical on rs2):
  - fwd1 = exmem_result if exmem_wb_en & exmem_rd!=0 & exmem_rd==rs1.
  - else memwb_result if memwb_wb_en & memwb_rd!=0 & memwb_rd==rs1.
  - else held rs1_val.
  - EX/MEM always wins over MEM/WB. Index 0 is never forwarded.
- Operand outputs:
  - val1 = fwd1.
  - val2 = use_imm ? imm : fwd2.
  - ex_store_data = fwd2.
- When ex_valid=0, outputs still follow the held fields, so they are don't-care downstream. Control bits must be 0 when ex_valid=0.
- Latency: an instruction accepted at edge N is visible on outputs after edge N. Throughput is one per cycle.
- flush together with hold drops the held instruction. Flush takes priority over hz and over id_valid.
- Reset mid-stall clears the stage; no partial state survives.

Decomposition:
- Package cpu_pkg:
  - exe_cmd_e enum: CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_NOR, CMD_XOR, CMD_SLL, CMD_SLA, CMD_SRL, CMD_SRA, CMD_NOP.
  - XLEN and REG_AW constants.
  - id_ex_t packed struct holding the registered fields.
- Sub-module fwd_mux: one 3-source priority forwarding selector, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst_n low mid-stream with ex_valid=1 -> ex_valid=0, exe_cmd=CMD_NOP, val1=val2=0 immediately, without waiting for a clock edge.
- Forward priority: held rs1=5; exmem_rd=5 with result 0x11; memwb_rd=5 with result 0x22 -> val1=0x11. Drop exmem_wb_en -> val1=0x22. Set rs1=0 with both matching -> val1=held rs1_val.
- Load-use: EX holds a load with rd=3; ID presents rs1=3, ex_ready=1 -> id_ready=0, next cycle ex_valid=0. Following cycle the instruction is accepted, and memwb_rd=3 result 0x44 gives val1=0x44.
- Hold refresh: ex_ready=0 for 3 cycles, rs2=7. MEM/WB forwards 0x99 for rd=7 in cycle 1 only -> val2 stays 0x99 in cycles 2-3 (use_imm=0).
- Flush: flush=1 together with id_valid=1 and ex_ready=0 -> id_ready=0, next cycle ex_valid=0, new instruction not loaded.
- Immediate/store: use_imm=1, imm=0xFFFF_FFF0, mem_write=1, rs2 forwarded 0x1234 -> val2=0xFFFF_FFF0, ex_store_data=0x1234.
